// File: rtl/signal_gen_scheduler.sv
// signal_gen_scheduler
//
// Round-robin owner of a single signal_generator. One requester is granted
// at a time. The scheduler latches that requester's pattern and effective
// frame period, and holds the generator in reset except during the burst.
// A burst is BURST full frames of Teff clocks each.
//
// Build option:
//   SCHED_ABORT_EN - when defined, a burst ends early at the first frame
//                    boundary where the owner's req is low. A frame is never
//                    cut short. When undefined, req is ignored while granted.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   req        per-requester request level
//   pat_in     requester i pattern at [i*WIDTH +: WIDTH]
//   period_in  requester i frame period (clocks) at [i*32 +: 32]
//   gen_reset  generator reset; low only while a burst is running
//   gen_N      latched pattern for the generator
//   gen_T1     latched effective frame period (never below WIDTH*T2)
//   grant      one-hot current owner, 0 when idle
//   done       one-cycle pulse on the owner's bit when its burst ends
//   busy       high while loading or running a burst
module signal_gen_scheduler #(
  parameter int WIDTH = 8,
  parameter int T2    = 9,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  pat_in,
  input  logic [NREQ*32-1:0]     period_in,
  output logic                   gen_reset,
  output logic [WIDTH-1:0]       gen_N,
  output logic [31:0]            gen_T1,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic                   busy
);

  localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] MIN_T   = 32'(WIDTH * T2);
  localparam logic [31:0] BURST_W = 32'(BURST);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [WIDTH-1:0]  gen_n_reg, gen_n_next;
  logic [31:0]       gen_t1_reg, gen_t1_next;
  logic [31:0]       cyc_reg, cyc_next;
  logic [31:0]       frm_reg, frm_next;

  // Unpacked views of the flat requester buses.
  logic [WIDTH-1:0]  pat_arr    [NREQ];
  logic [31:0]       period_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign pat_arr[gi]    = pat_in[gi*WIDTH +: WIDTH];
      assign period_arr[gi] = period_in[gi*32 +: 32];
    end
  endgenerate

  // A period of 0, or one shorter than a full pattern, is replaced by
  // one full pattern length so that a frame always fits.
  function automatic logic [31:0] eff_period(input logic [31:0] p);
    return (p < MIN_T) ? MIN_T : p;
  endfunction

  // Round-robin search. Offsets are scanned from high to low so that the
  // last hit, which is the one that wins, is the nearest set bit at or
  // above the pointer.
  logic          found;
  logic [PW-1:0] sel;
  int            cand;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = int'(ptr_reg) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        found = 1'b1;
        sel   = PW'(cand);
      end
    end
  end

  // Early termination request at a frame boundary.
  logic abort;
`ifdef SCHED_ABORT_EN
  assign abort = ~|(req & grant_reg);
`else
  assign abort = 1'b0;
`endif

  logic frame_end;
  assign frame_end = (cyc_reg == gen_t1_reg - 32'd1);

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    grant_next  = grant_reg;
    gen_n_next  = gen_n_reg;
    gen_t1_next = gen_t1_reg;
    cyc_next    = cyc_reg;
    frm_next    = frm_reg;
    gen_reset   = 1'b1;
    busy        = 1'b0;
    done        = '0;

    case (state_reg)
      S_IDLE: begin
        grant_next = '0;
        if (found) begin
          grant_next  = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          gen_n_next  = pat_arr[sel];
          gen_t1_next = eff_period(period_arr[sel]);
          ptr_next    = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        cyc_next   = '0;
        frm_next   = '0;
        state_next = S_RUN;
      end
      S_RUN: begin
        gen_reset = 1'b0;
        busy      = 1'b1;
        if (frame_end) begin
          cyc_next = '0;
          frm_next = frm_reg + 32'd1;
          if ((frm_reg + 32'd1 == BURST_W) || abort) begin
            state_next = S_DONE;
          end
        end else begin
          cyc_next = cyc_reg + 32'd1;
        end
      end
      S_DONE: begin
        done       = grant_reg;
        grant_next = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= '0;
      grant_reg  <= '0;
      gen_n_reg  <= '0;
      gen_t1_reg <= '0;
      cyc_reg    <= '0;
      frm_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      grant_reg  <= grant_next;
      gen_n_reg  <= gen_n_next;
      gen_t1_reg <= gen_t1_next;
      cyc_reg    <= cyc_next;
      frm_reg    <= frm_next;
    end
  end

  assign gen_N  = gen_n_reg;
  assign gen_T1 = gen_t1_reg;
  assign grant  = grant_reg;

endmodule

// File: tb/tb_signal_gen_scheduler.sv
// tb_signal_gen_scheduler
//
// Directed bench for signal_gen_scheduler (WIDTH=8, T2=9, NREQ=4, BURST=4).
// A timeline model describes each grant as: a load cycle, a run that ends at
// the first frame boundary where the burst is complete (or aborted), and a
// done cycle. The model is checked against the DUT on every cycle. The
// literal checks in the stimulus pin the model itself to hand-computed
// values.
module tb_signal_gen_scheduler;

  localparam int WIDTH = 8;
  localparam int T2    = 9;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int MIN_T = WIDTH * T2;
`ifdef SCHED_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] pat_in;
  logic [NREQ*32-1:0]    period_in;
  logic                  gen_reset;
  logic [WIDTH-1:0]      gen_N;
  logic [31:0]           gen_T1;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;

  signal_gen_scheduler #(.WIDTH(WIDTH), .T2(T2), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .pat_in(pat_in), .period_in(period_in),
    .gen_reset(gen_reset), .gen_N(gen_N), .gen_T1(gen_T1), .grant(grant),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_printed = 0;
  bit check_en = 1'b0;

  // ---------------- timeline model ----------------
  int               m_owner = -1;  // granted requester, -1 when idle
  int               m_t     = 0;   // cycles since the grant edge (0 = load cycle)
  int               m_len   = 0;   // run length once known, 0 while unknown
  int               m_ptr   = 0;
  logic [WIDTH-1:0] m_n     = '0;
  logic [31:0]      m_t1    = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1; m_t = 0; m_len = 0; m_ptr = 0; m_n = '0; m_t1 = '0;
    end else if (m_owner < 0) begin
      int pick;
      logic [31:0] p;
      pick = -1;
      for (int off = 0; off < NREQ; off++) begin
        if (pick < 0 && req[(m_ptr + off) % NREQ]) pick = (m_ptr + off) % NREQ;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_t     = 0;
        m_len   = 0;
        m_ptr   = (pick + 1) % NREQ;
        m_n     = pat_in[pick*WIDTH +: WIDTH];
        p       = period_in[pick*32 +: 32];
        m_t1    = (p < 32'(MIN_T)) ? 32'(MIN_T) : p;
      end
    end else begin
      // Run cycle m_t closes a frame when it is a multiple of the period.
      if (m_t >= 1 && m_len == 0 && (m_t % int'(m_t1)) == 0) begin
        if ((m_t / int'(m_t1)) == BURST || (ABORT && !req[m_owner])) m_len = m_t;
      end
      if (m_len != 0 && m_t == m_len + 1) m_owner = -1;
      else m_t++;
    end
  end

  logic            e_done, e_reset, e_busy;
  logic [NREQ-1:0] e_grant, e_donev;

  always @(posedge clk) begin
    #1;
    if (check_en) begin
      e_done  = (m_owner >= 0) && (m_len != 0) && (m_t == m_len + 1);
      e_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      e_reset = !((m_owner >= 0) && (m_t >= 1) && !e_done);
      e_busy  = (m_owner >= 0) && !e_done;
      e_donev = e_done ? e_grant : '0;
      n_vec++;
      if (gen_reset !== e_reset || grant !== e_grant || done !== e_donev ||
          busy !== e_busy || gen_N !== m_n || gen_T1 !== m_t1) begin
        n_bad++;
        if (n_printed < 10) begin
          n_printed++;
          $display("FAIL cycle_model t=%0t: got rst=%b gnt=%b done=%b busy=%b N=%h T1=%0d, need rst=%b gnt=%b done=%b busy=%b N=%h T1=%0d",
                   $time, gen_reset, grant, done, busy, gen_N, gen_T1,
                   e_reset, e_grant, e_donev, e_busy, m_n, m_t1);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) need %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s = %0d (0x%0h)", name, act, act);
    end
  endtask

  // Waits at negedges for a grant; reports how many negedges it took.
  task automatic wait_grant(output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (grant != '0) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL grant_timeout: got no grant after %0d cycles, need a grant", cycles);
    end
  endtask

  // Runs until the done pulse (returns on the done cycle), counting cycles
  // with gen_reset low. Optionally drops req and scrambles the owner's
  // inputs once drop_after low cycles have been seen.
  task automatic run_burst(input int drop_after, output int lows, output logic [NREQ-1:0] d);
    bit seen;
    seen = 1'b0;
    lows = 0;
    d    = '0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done != '0) begin
        d = done;
        seen = 1'b1;
      end else begin
        if (gen_reset == 1'b0) lows++;
        if (drop_after > 0 && lows == drop_after) begin
          req = '0;
          pat_in[7:0] = 8'h3C;
          period_in[31:0] = 32'd5;
        end
      end
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: got no done pulse after %0d low cycles, need one", lows);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [NREQ-1:0] rr_grant [5];
  logic [31:0]     rr_t1    [5];
  int              rr_lows  [5];
  int              cyc, lows;
  logic [NREQ-1:0] d;

  initial begin
    rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_t1    = '{32'd72, 32'd72, 32'd72, 32'd73, 32'd72};
    rr_lows  = '{288, 288, 288, 292, 288};

    reset = 1'b1; req = '0; pat_in = '0; period_in = '0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check("reset_gen_reset", 32'(gen_reset), 32'd1);
    check("reset_grant",     32'(grant),     32'd0);
    check("reset_gen_N",     32'(gen_N),     32'd0);
    check("reset_gen_T1",    gen_T1,         32'd0);
    check("reset_busy_done", {busy, done},   32'd0);
    reset = 1'b0;

    // Single requester, period 1000: grant at +1, reset low at +2 for 4000.
    @(negedge clk);
    pat_in[7:0] = 8'hED; period_in[31:0] = 32'd1000; req = 4'b0001;
    wait_grant(cyc);
    check("t1_grant_latency", 32'(cyc), 32'd1);
    check("t1_grant",     32'(grant), 32'b0001);
    check("t1_gen_N",     32'(gen_N), 32'hED);
    check("t1_gen_T1",    gen_T1, 32'd1000);
    check("t1_load_reset", 32'(gen_reset), 32'd1);
    @(negedge clk);
    check("t1_reset_low_at_2", 32'(gen_reset), 32'd0);
    run_burst(0, lows, d);
    check("t1_run_cycles", 32'(lows + 1), 32'd4000);
    check("t1_done",       32'(d), 32'b0001);
    check("t1_grant_in_done", 32'(grant), 32'b0001);
    req = '0;

    // Round-robin with all requesters held high; periods cover 0, below,
    // just below and just above one pattern length.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pat_in = {8'h44, 8'h33, 8'h22, 8'h11};
    period_in = {32'd73, 32'd71, 32'd50, 32'd0};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(cyc);
      check($sformatf("rr%0d_grant", k),  32'(grant), 32'(rr_grant[k]));
      check($sformatf("rr%0d_gen_T1", k), gen_T1, rr_t1[k]);
      run_burst(0, lows, d);
      check($sformatf("rr%0d_run_cycles", k), 32'(lows), 32'(rr_lows[k]));
      check($sformatf("rr%0d_done", k), 32'(d), 32'(rr_grant[k]));
    end
    req = '0;

    // Reset 500 cycles into a run: no done pulse, then normal service.
    @(negedge clk);
    pat_in[7:0] = 8'hED; period_in[31:0] = 32'd1000; req = 4'b0001;
    wait_grant(cyc);
    repeat (501) @(negedge clk);
    check("mid_before_reset_low", 32'(gen_reset), 32'd0);
    reset = 1'b1; req = '0;
    @(negedge clk);
    check("mid_gen_reset", 32'(gen_reset), 32'd1);
    check("mid_grant",     32'(grant), 32'd0);
    check("mid_done_busy", {busy, done}, 32'd0);
    reset = 1'b0;
    pat_in[15:8] = 8'h5A; period_in[63:32] = 32'd50; req = 4'b0010;
    wait_grant(cyc);
    check("mid_new_grant", 32'(grant), 32'b0010);
    check("mid_new_gen_N", 32'(gen_N), 32'h5A);
    run_burst(0, lows, d);
    check("mid_new_run_cycles", 32'(lows), 32'd288);
    check("mid_new_done", 32'(d), 32'b0010);
    req = '0;

    // req dropped and inputs changed inside frame 2 of a Teff=100 burst.
    @(negedge clk);
    pat_in[7:0] = 8'hA5; period_in[31:0] = 32'd100; req = 4'b0001;
    wait_grant(cyc);
    check("ab_gen_T1", gen_T1, 32'd100);
    run_burst(150, lows, d);
    check("ab_run_cycles", 32'(lows), ABORT ? 32'd200 : 32'd400);
    check("ab_done", 32'(d), 32'b0001);
    check("ab_gen_N_frozen", 32'(gen_N), 32'hA5);
    check("ab_gen_T1_frozen", gen_T1, 32'd100);
    repeat (4) @(negedge clk);
    check("ab_idle_grant", 32'(grant), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by %0t, need completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
